// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack side plus the control-unit side.
// master = fetch_unit, slave = memory/core environment driving it.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;
  logic        instr_valid;
  logic        instr_done;
  logic        PC_SRC;
  logic        JALR;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;

  modport master (
    output imem_req, imem_addr, instr, opcode, funct3, funct7,
           instr_valid, pc, pc_plus4, trap,
    input  imem_ack, imem_rdata, instr_done, PC_SRC, JALR, imm, rs1_val
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, funct3, funct7,
           instr_valid, pc, pc_plus4, trap,
    output imem_ack, imem_rdata, instr_done, PC_SRC, JALR, imm, rs1_val
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC, fetches via req/ack, applies branch/jump decisions; 1 cycle ack->valid.
// Memory stalls hold the request (one cycle per wait); the core stalls by withholding instr_done.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {REQ, WAIT, VALID, TRAP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_trap;
  logic [31:0] w_next_pc;
  logic        w_fetching;

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (bus.JALR) begin
      w_next_pc = (bus.rs1_val + bus.imm) & ~32'h1;
    end else if (bus.PC_SRC) begin
      w_next_pc = r_pc + bus.imm;
    end
  end

  // Gating with RST keeps the request low during reset so a stale ack cannot land.
  assign w_fetching = !RST && ((r_state == REQ) || (r_state == WAIT));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= REQ;
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_instr_valid <= 1'b0;
      r_trap        <= 1'b0;
    end else begin
      case (r_state)
        REQ, WAIT: begin
          if (bus.imem_ack) begin
            r_instr       <= bus.imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= VALID;
          end else begin
            r_state <= WAIT;
          end
        end
        VALID: begin
          if (bus.instr_done) begin
            r_instr_valid <= 1'b0;
            if (w_next_pc[1:0] != 2'b00) begin
              r_trap  <= 1'b1;
              r_state <= TRAP;
            end else begin
              r_pc    <= w_next_pc;
              r_instr <= NOP;
              r_state <= REQ;
            end
          end
        end
        default: begin
          r_state <= TRAP;
        end
      endcase
    end
  end

  assign bus.imem_req    = w_fetching;
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.opcode      = r_instr[6:0];
  assign bus.funct3      = r_instr[14:12];
  assign bus.funct7      = r_instr[30];
  assign bus.instr_valid = r_instr_valid;
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = r_pc + 32'd4;
  assign bus.trap        = r_trap;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the instruction fields consumed by the control unit (UnidadControl) and acts on that unit's branch/jump decisions. It holds the program counter and fetches 32-bit words from instruction memory through a req/ack handshake. It presents `opcode`, `funct3` and `funct7` to the control unit, then computes the next PC from `PC_SRC`, `JALR`, the immediate and rs1.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- NOP, 32'h0000_0013, value held in the instruction register while no valid word is present (ADDI x0,x0,0).
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- imem_req  out  1  fetch request; held high until `imem_ack`.
- imem_addr  out  32  fetch address; equals `pc` while `imem_req`=1.
- imem_ack  in  1  memory has `imem_rdata` valid this cycle; ignored when `imem_req`=0.
- imem_rdata  in  32  fetched word.
- instr  out  32  instruction register.
- opcode  out  7  `instr[6:0]`.
- funct3  out  3  `instr[14:12]`.
- funct7  out  1  `instr[30]` (the single distinguishing bit used by the control unit).
- instr_valid  out  1  `instr` is a fetched word awaiting execution.
- instr_done  in  1  one-cycle pulse from the core: current instruction executed, `PC_SRC`/`JALR`/`imm`/`rs1_val` valid this cycle.
- PC_SRC  in  1  from control unit: take PC-relative target.
- JALR  in  1  from control unit: take register target; has priority over `PC_SRC`.
- imm  in  32  sign-extended immediate.
- rs1_val  in  32  rs1 register value.
- pc  out  32  address of `instr`.
- pc_plus4  out  32  `pc + 4` (mod 2^32), for link writeback.
- trap  out  1  misaligned next PC detected; sticky until reset.

## Operation
- States: REQ, WAIT, VALID, TRAP.
- REQ: `imem_req`=1. If `imem_ack`=1 in the same cycle, latch `imem_rdata` into `instr` and go to VALID. Otherwise go to WAIT.
- WAIT: `imem_req`=1, address unchanged. On `imem_ack`, latch and go to VALID; otherwise stay.
- VALID: `instr_valid`=1 and `imem_req`=0. `instr` and `pc` are frozen. On `instr_done`, compute the next PC:
  - `JALR`=1: `(rs1_val + imm) & ~32'h1`
  - else `PC_SRC`=1: `pc + imm`
  - else: `pc + 4`
  All sums are 32-bit and wrap modulo 2^32.
- After the next-PC computation: if `next[1:0]`≠0, go to TRAP; `pc` keeps the faulting instruction's address and `trap`=1. Otherwise load `pc`←next, set `instr`←NOP, go to REQ.
- `instr_done` outside VALID is ignored. `JALR`, `PC_SRC`, `imm` and `rs1_val` are sampled only on `instr_done`.
- TRAP: all outputs frozen, `imem_req`=0, `instr_valid`=0; only RST exits.
- Reset values: `pc`=RESET_PC, `pc_plus4`=RESET_PC+4, `instr`=NOP (so `opcode`=7'b0010011, `funct3`=0, `funct7`=0), `instr_valid`=0, `imem_req`=0, `trap`=0, state=REQ.
- Reset asserted mid-transaction (WAIT or VALID) aborts immediately; any later `imem_ack` belonging to the aborted request is ignored unless it arrives while `imem_req`=1.

## Timing
- First `imem_req` is in the first cycle after RST deasserts.
- Zero-wait memory (ack in the request cycle): `instr_valid` rises at the next edge. So there is 1 cycle from request to valid, and the fetch-to-fetch period is 2 cycles plus the execute time.
- Each wait cycle of `imem_ack` adds exactly one cycle.
- The next `imem_req` rises in the cycle after `instr_done`, with `imem_addr` = new PC.
- `opcode`/`funct3`/`funct7` are registered-derived; they change only at the edge that sets `instr_valid` or leaves VALID.
- `pc_plus4` is combinational from `pc`.

## Test plan
- **Reset:** hold RST, then release with RESET_PC=0 → cycle 1: `imem_req`=1, `imem_addr`=0; outputs before that: `opcode`=0010011, `instr_valid`=0.
- **Zero-wait fetch:** ack the same cycle with 0x00000033 (ADD) → next cycle `instr_valid`=1, `opcode`=0110011, `funct3`=0, `funct7`=0. Then `instr_done` with PC_SRC=0 → `imem_addr`=4. Fetch 0x40000033 (SUB) → `funct7`=1.
- **Wait states:** delay ack 3 cycles → `imem_addr` stable, `instr_valid` rises 1 cycle after ack.
- **Branch, jump and wrap-around:**
  - at pc=8, PC_SRC=1, imm=-8 → next fetch at 0;
  - JALR=1, rs1_val=0x101, imm=0x10 → next fetch at 0x110;
  - pc=0xFFFFFFFC sequential → next fetch at 0;
  - JALR and PC_SRC both 1 → the JALR target is taken.
- **Misaligned target:** PC_SRC=1, imm=2 → `trap`=1, `imem_req` stays 0, `pc` unchanged; further `instr_done` pulses have no effect.
- **Reset mid-WAIT:** assert RST while in WAIT at pc=0x20 → `pc`=0, `imem_req`=0, `instr`=NOP. A stale ack during RST is ignored.
